pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the fetch stage's stall and PC-select inputs, and the flush inputs of the IF/ID and ID/EX pipeline registers.
- Arbitrates three sources of pipeline disturbance:
  - load-use hazards;
  - taken branches/jumps resolved in EX;
  - a multi-cycle EX unit (mult/div) that occupies EX for MC_CYCLES cycles.
- Also accepts an external freeze and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 81 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage pipeline covering load-use,
// taken branches, multi-cycle EX ops and external freeze, with a saturating stall counter.
module pipe_hazard_ctrl #(
   parameter int MC_CYCLES = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mc_start,
   input  logic             br_taken,
   input  logic             ext_hold,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             pc_sel,
   output logic             flush_id,
   output logic             flush_ex,
   output logic             bubble_mem,
   output logic             mc_busy,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic {RUN, MC_WAIT} state_t;
   state_t     state, state_nx;
   logic [3:0] mc_cnt, mc_cnt_nx;
   logic       load_use;
   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         mc_cnt    <= 4'd0;
         stall_cnt <= '0;
      end else begin
         state  <= state_nx;
         mc_cnt <= mc_cnt_nx;
         if (stall_if && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
   // Outputs are forced low while reset is held so downstream stages see no stray control.
   always_comb begin
      state_nx   = state;
      mc_cnt_nx  = mc_cnt;
      stall_if   = 1'b0;
      stall_id   = 1'b0;
      stall_ex   = 1'b0;
      pc_sel     = 1'b0;
      flush_id   = 1'b0;
      flush_ex   = 1'b0;
      bubble_mem = 1'b0;
      mc_busy    = 1'b0;
      if (!rst_n) begin
         state_nx  = RUN;
         mc_cnt_nx = 4'd0;
      end else if (ext_hold) begin
         {stall_if, stall_id, stall_ex, bubble_mem} = 4'hf;
         mc_busy = (state == MC_WAIT);
      end else if (state == MC_WAIT) begin
         mc_busy = 1'b1;
         if (mc_cnt != 4'd0) begin
            {stall_if, stall_id, stall_ex, bubble_mem} = 4'hf;
            mc_cnt_nx = mc_cnt - 4'd1;
         end else begin
            state_nx = RUN;
         end
      end else if (ex_mc_start) begin
         {stall_if, stall_id, stall_ex, bubble_mem, mc_busy} = 5'h1f;
         state_nx  = MC_WAIT;
         mc_cnt_nx = 4'(MC_CYCLES - 2);
      end else if (br_taken) begin
         {pc_sel, flush_id, flush_ex} = 3'b111;
      end else if (load_use) begin
         {stall_if, stall_id, flush_ex} = 3'b111;
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenario tests for pipe_hazard_ctrl.
// Output vector order: stall_if stall_id stall_ex pc_sel flush_id flush_ex bubble_mem mc_busy.
module tb_pipe_hazard_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, ex_rd;
   logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_mc_start, br_taken, ext_hold;
   logic        stall_if, stall_id, stall_ex, pc_sel, flush_id, flush_ex, bubble_mem, mc_busy;
   logic [15:0] stall_cnt;
   logic [7:0]  outs;
   int          checks = 0;
   int          errors = 0;

   pipe_hazard_ctrl #(.MC_CYCLES(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
      .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .ex_mc_start(ex_mc_start), .br_taken(br_taken), .ext_hold(ext_hold),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .pc_sel(pc_sel),
      .flush_id(flush_id), .flush_ex(flush_ex), .bubble_mem(bubble_mem),
      .mc_busy(mc_busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;
   assign outs = {stall_if, stall_id, stall_ex, pc_sel, flush_id, flush_ex, bubble_mem, mc_busy};

   task automatic idle();
      id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
      ex_mc_start = 1'b0; br_taken = 1'b0; ext_hold = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      ext_hold = 1'b1; ex_mc_start = 1'b1; br_taken = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (outs !== 8'h00) begin errors++; $display("FAIL reset_outs got %b want %b", outs, 8'h00); end
      checks++;
      if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      #1;
      checks++;
      if (outs !== 8'h00) begin errors++; $display("FAIL idle_outs got %b want %b", outs, 8'h00); end
      @(negedge clk); #1;
      checks++;
      if (stall_cnt !== 16'd0) begin errors++; $display("FAIL idle_cnt got %0d want 0", stall_cnt); end
   endtask

   task automatic test_load_use();
      logic [4:0] rd [0:5];
      logic [4:0] rs [0:5];
      logic [4:0] rt [0:5];
      logic       urs [0:5];
      logic       urt [0:5];
      logic       mr [0:5];
      logic [7:0] ev [0:5];
      logic [15:0] c0;
      rd  = '{5'd5, 5'd0, 5'd7, 5'd9, 5'd9, 5'd3};
      rs  = '{5'd5, 5'd0, 5'd1, 5'd9, 5'd2, 5'd3};
      rt  = '{5'd0, 5'd0, 5'd7, 5'd9, 5'd9, 5'd3};
      urs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      urt = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      mr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      ev  = '{8'b1100_0100, 8'h00, 8'b1100_0100, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         idle();
         ex_rd = rd[i]; id_rs = rs[i]; id_rt = rt[i];
         id_uses_rs = urs[i]; id_uses_rt = urt[i]; ex_mem_read = mr[i];
         #1;
         c0 = stall_cnt;
         checks++;
         if (outs !== ev[i]) begin errors++; $display("FAIL load_use[%0d] got %b want %b", i, outs, ev[i]); end
         @(negedge clk);
         idle();
         #1;
         checks++;
         if (stall_cnt !== c0 + 16'(ev[i][7])) begin
            errors++; $display("FAIL load_use_cnt[%0d] got %0d want %0d", i, stall_cnt, c0 + 16'(ev[i][7]));
         end
         checks++;
         if (outs !== 8'h00) begin errors++; $display("FAIL load_use_clear[%0d] got %b want 0", i, outs); end
      end
   endtask

   task automatic test_branch();
      logic [15:0] c0;
      @(negedge clk);
      idle();
      br_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1;
      #1;
      c0 = stall_cnt;
      checks++;
      if (outs !== 8'b0001_1100) begin errors++; $display("FAIL branch_outs got %b want %b", outs, 8'b0001_1100); end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (stall_cnt !== c0) begin errors++; $display("FAIL branch_cnt got %0d want %0d", stall_cnt, c0); end
   endtask

   task automatic test_multicycle();
      logic [7:0] ev [0:4];
      logic [15:0] c0;
      ev = '{8'b1110_0011, 8'b1110_0011, 8'b1110_0011, 8'b0000_0001, 8'h00};
      @(negedge clk);
      idle();
      #1;
      c0 = stall_cnt;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         idle();
         ex_mc_start = (i == 0 || i == 3);
         if (i == 1) begin
            br_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd6; id_rt = 5'd6; id_uses_rt = 1'b1;
         end
         #1;
         checks++;
         if (outs !== ev[i]) begin errors++; $display("FAIL mc[%0d] got %b want %b", i, outs, ev[i]); end
      end
      checks++;
      if (stall_cnt !== c0 + 16'd3) begin errors++; $display("FAIL mc_cnt got %0d want %0d", stall_cnt, c0 + 16'd3); end
   endtask

   task automatic test_hold();
      logic [7:0] ev [0:6];
      logic [15:0] c0;
      ev = '{8'b1110_0011, 8'b1110_0011, 8'b1110_0011, 8'b1110_0011,
             8'b1110_0011, 8'b0000_0001, 8'h00};
      @(negedge clk);
      idle();
      #1;
      c0 = stall_cnt;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) @(negedge clk);
         idle();
         ex_mc_start = (i == 0);
         ext_hold = (i == 2 || i == 3);
         #1;
         checks++;
         if (outs !== ev[i]) begin errors++; $display("FAIL hold_mc[%0d] got %b want %b", i, outs, ev[i]); end
      end
      checks++;
      if (stall_cnt !== c0 + 16'd5) begin errors++; $display("FAIL hold_mc_cnt got %0d want %0d", stall_cnt, c0 + 16'd5); end
      @(negedge clk);
      idle();
      ext_hold = 1'b1; br_taken = 1'b1;
      #1;
      checks++;
      if (outs !== 8'b1110_0010) begin errors++; $display("FAIL hold_br got %b want %b", outs, 8'b1110_0010); end
      @(negedge clk);
      ext_hold = 1'b0;
      #1;
      checks++;
      if (outs !== 8'b0001_1100) begin errors++; $display("FAIL hold_br_release got %b want %b", outs, 8'b0001_1100); end
   endtask

   task automatic test_reset_mid_mc();
      @(negedge clk);
      idle();
      ex_mc_start = 1'b1;
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (mc_busy !== 1'b1) begin errors++; $display("FAIL mid_mc_busy got %b want 1", mc_busy); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (outs !== 8'h00) begin errors++; $display("FAIL mid_mc_reset got %b want 0", outs); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (outs !== 8'h00) begin errors++; $display("FAIL mid_mc_after got %b want 0", outs); end
      checks++;
      if (stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_mc_cnt got %0d want 0", stall_cnt); end
   endtask

   task automatic test_saturate();
      @(negedge clk);
      idle();
      ext_hold = 1'b1;
      repeat (70000) @(negedge clk);
      #1;
      checks++;
      if (stall_cnt !== 16'hffff) begin errors++; $display("FAIL sat_cnt got %0d want 65535", stall_cnt); end
      repeat (3) @(negedge clk);
      idle();
      #1;
      checks++;
      if (stall_cnt !== 16'hffff) begin errors++; $display("FAIL sat_hold got %0d want 65535", stall_cnt); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_multicycle();
      test_hold();
      test_reset_mid_mc();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
